dmem_responder: RTL and testbench

- Data-memory responder serving the execute stage's LDR/STR requests. Completes the memory side of the load/store path that the ALU initiates.
- Accepts one word-addressed request per handshake and applies a fixed, programmable number of wait states. Returns read data or a write acknowledge on a valid/ready response channel.
- Owns the data-memory array internally.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for LDR/STR requests: one outstanding word access with WAIT_CYCLES wait states.
// Define DMEM_ACCESS_CNT_EN to add the ld_count/st_count/err_count access counters.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int MEM_DEPTH   = 65536,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    // Both channels transfer on a rising edge where valid && ready; valid never
    // depends combinationally on ready, and the payload is held stable while valid waits.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count,
    output logic [15:0]       err_count,
`endif
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam bit         FULL_MAP  = (longint'(MEM_DEPTH) >= (longint'(1) << ADDR_W));
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // With a fully mapped address space the range check folds away entirely.
    if (FULL_MAP) begin : g_full_map
        assign in_range = 1'b1;
    end else begin : g_part_map
        assign in_range = (addr_q < ADDR_W'(MEM_DEPTH));
    end

    assign mem_idx = addr_q[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d       = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wait_cnt_d = 4'd0;
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = S_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                err_d   = !in_range;
                rdata_d = (in_range && !wr_q) ? mem[mem_idx] : '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // A store whose ACCESS edge meets rst is dropped; the array itself is never cleared.
    assign mem_we = (state_q == S_ACCESS) && wr_q && in_range && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign state_dbg = state_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt_q, ld_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        ld_cnt_d  = ld_cnt_q;
        st_cnt_d  = st_cnt_q;
        err_cnt_d = err_cnt_q;
        if (state_q == S_ACCESS) begin
            if (!in_range) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else if (wr_q) begin
                st_cnt_d = st_cnt_q + 32'd1;
            end else begin
                ld_cnt_d = ld_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q  <= 32'd0;
            st_cnt_q  <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            ld_cnt_q  <= ld_cnt_d;
            st_cnt_q  <= st_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ld_count  = ld_cnt_q;
    assign st_count  = st_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has 1 wait state and 1024 words, instance 1 has no wait states and a full map.
// A transaction-level model checks every output of both instances on every negedge.
module tb_dmem_responder;

    localparam int W_A = 1;
    localparam int D_A = 1024;
    localparam int W_B = 0;
    localparam int D_B = 65536;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [15:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic [1:0]  state_dbg [2];
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_count  [2];
    logic [31:0] st_count  [2];
    logic [15:0] err_count [2];
    int          ld_m [2];
    int          st_m [2];
    int          er_m [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmem_responder #(.DATA_W(32), .ADDR_W(16), .MEM_DEPTH(D_A), .WAIT_CYCLES(W_A)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]),
`ifdef DMEM_ACCESS_CNT_EN
        .ld_count(ld_count[0]), .st_count(st_count[0]), .err_count(err_count[0]),
`endif
        .state_dbg(state_dbg[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(16), .MEM_DEPTH(D_B), .WAIT_CYCLES(W_B)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]),
`ifdef DMEM_ACCESS_CNT_EN
        .ld_count(ld_count[1]), .st_count(st_count[1]), .err_count(err_count[1]),
`endif
        .state_dbg(state_dbg[1])
    );

    task automatic chk32(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input int inst, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? W_A : W_B;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? D_A : D_B;
    endfunction

    // ---------------- clock/reset bookkeeping ----------------
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model + compare ----------------
    logic        pend    [2];
    int          acc     [2];
    logic        m_wr    [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];
    logic        m_known [2];
    logic [31:0] mem_m   [int];
    bit          model_on = 1'b0;

    always @(negedge clk) begin
        logic ev;
        int   key;
        for (int i = 0; i < 2; i++) begin
            ev = pend[i] && (cyc >= acc[i] + wait_of(i) + 2);
            if (model_on) begin
                chkb("busy", i, busy[i], pend[i]);
                chkb("req_ready", i, req_ready[i], !pend[i]);
                chkb("rsp_valid", i, rsp_valid[i], ev);
                if (ev) begin
                    chkb("rsp_err", i, rsp_err[i], m_err[i]);
                    if (m_known[i]) chk32("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
                end
`ifdef DMEM_ACCESS_CNT_EN
                chk32("ld_count", i, ld_count[i], 32'(ld_m[i]));
                chk32("st_count", i, st_count[i], 32'(st_m[i]));
                chk32("err_count", i, {16'd0, err_count[i]}, 32'(er_m[i] & 32'hFFFF));
`endif
            end
            if (rst) begin
                model_on = 1'b1;
                pend[i]  = 1'b0;
`ifdef DMEM_ACCESS_CNT_EN
                ld_m[i] = 0;
                st_m[i] = 0;
                er_m[i] = 0;
`endif
            end else if (model_on) begin
                if (pend[i]) begin
                    if (cyc == acc[i] + wait_of(i) + 1) begin
                        key = i * 65536 + int'(m_addr[i]);
`ifdef DMEM_ACCESS_CNT_EN
                        if (m_err[i]) er_m[i]++;
                        else if (m_wr[i]) st_m[i]++;
                        else ld_m[i]++;
`endif
                        if (!m_err[i] && m_wr[i]) mem_m[key] = m_wdata[i];
                    end
                    if (ev && rsp_ready[i]) pend[i] = 1'b0;
                end else if (req_valid[i]) begin
                    pend[i]    = 1'b1;
                    acc[i]     = cyc;
                    m_wr[i]    = req_write[i];
                    m_addr[i]  = req_addr[i];
                    m_wdata[i] = req_wdata[i];
                    key        = i * 65536 + int'(req_addr[i]);
                    m_err[i]   = (int'(req_addr[i]) >= depth_of(i));
                    m_known[i] = 1'b1;
                    m_rdata[i] = 32'd0;
                    if (!m_err[i] && !req_write[i]) begin
                        if (mem_m.exists(key)) m_rdata[i] = mem_m[key];
                        else m_known[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input int i, input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input int hold, output int lat, output logic [31:0] rd, output logic er);
        int n;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        rsp_ready[i] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("accept_timeout", i, (n < 50), 1'b1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_write[i] = !wr;
        req_addr[i]  = a ^ 16'h5555;
        req_wdata[i] = ~d;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[i] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chkb("rsp_timeout", i, (lat < 50), 1'b1);
        rd = rsp_rdata[i];
        er = rsp_err[i];
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    task automatic store_then_reset(input int i, input logic [15:0] a, input logic [31:0] d, input int k);
        req_valid[i] = 1'b1;
        req_write[i] = 1'b1;
        req_addr[i]  = a;
        req_wdata[i] = d;
        rsp_ready[i] = 1'b0;
        @(negedge clk);
        chkb("abort_accept_ready", i, req_ready[i], 1'b1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        repeat (k) begin
            @(posedge clk); #1;
        end
        pulse_reset();
        @(negedge clk);
        chkb("abort_busy", i, busy[i], 1'b0);
        chkb("abort_req_ready", i, req_ready[i], 1'b1);
        chkb("abort_rsp_valid", i, rsp_valid[i], 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] tbl_addr [4] = '{16'h0002, 16'h0155, 16'h02AA, 16'h03FE};

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [15:0] a;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 16'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b0;
            pend[i]      = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chkb("reset_req_ready", i, req_ready[i], 1'b1);
            chkb("reset_rsp_valid", i, rsp_valid[i], 1'b0);
            chkb("reset_busy", i, busy[i], 1'b0);
            chk32("reset_rsp_rdata", i, rsp_rdata[i], 32'd0);
            chkb("reset_rsp_err", i, rsp_err[i], 1'b0);
        end
        @(posedge clk); #1;

        // store then load, one wait state
        send(0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, lat, rd, er);
        chkb("st_err", 0, er, 1'b0);
        chk32("st_rdata", 0, rd, 32'd0);
        chk32("st_latency", 0, lat, 32'd3);
        send(0, 1'b0, 16'h0010, 32'h0, 0, lat, rd, er);
        chk32("ld_rdata", 0, rd, 32'hDEADBEEF);
        chk32("ld_latency", 0, lat, 32'd3);

        // response back-pressure: ready low for 5 valid cycles
        send(0, 1'b0, 16'h0010, 32'h0, 4, lat, rd, er);
        chk32("bp_rdata", 0, rd, 32'hDEADBEEF);
        @(negedge clk);
        chkb("bp_ready_after", 0, req_ready[0], 1'b1);
        @(posedge clk); #1;

        // out-of-range on the 1024-word instance, neighbours untouched
        send(0, 1'b1, 16'h03FF, 32'hCAFEF00D, 0, lat, rd, er);
        send(0, 1'b1, 16'h0000, 32'h0BADF00D, 0, lat, rd, er);
        send(0, 1'b1, 16'h0400, 32'h12345678, 0, lat, rd, er);
        chkb("oor_st_err", 0, er, 1'b1);
        chk32("oor_st_rdata", 0, rd, 32'd0);
        send(0, 1'b0, 16'h0400, 32'h0, 0, lat, rd, er);
        chkb("oor_ld_err", 0, er, 1'b1);
        chk32("oor_ld_rdata", 0, rd, 32'd0);
        send(0, 1'b0, 16'hFFFF, 32'h0, 0, lat, rd, er);
        chkb("oor_top_err", 0, er, 1'b1);
        send(0, 1'b0, 16'h03FF, 32'h0, 0, lat, rd, er);
        chk32("edge_ld_rdata", 0, rd, 32'hCAFEF00D);
        chkb("edge_ld_err", 0, er, 1'b0);
        send(0, 1'b0, 16'h0000, 32'h0, 0, lat, rd, er);
        chk32("alias_ld_rdata", 0, rd, 32'h0BADF00D);

        // zero wait states, wdata toggled after accept
        send(1, 1'b1, 16'h0001, 32'hA5A5A5A5, 0, lat, rd, er);
        chk32("w0_st_latency", 1, lat, 32'd2);
        send(1, 1'b0, 16'h0001, 32'h0, 0, lat, rd, er);
        chk32("w0_ld_rdata", 1, rd, 32'hA5A5A5A5);
        chk32("w0_ld_latency", 1, lat, 32'd2);
        send(1, 1'b1, 16'hFFFF, 32'h600DCAFE, 0, lat, rd, er);
        send(1, 1'b0, 16'hFFFF, 32'h0, 0, lat, rd, er);
        chkb("full_map_err", 1, er, 1'b0);
        chk32("full_map_rdata", 1, rd, 32'h600DCAFE);

        // store/load table on both instances
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                a = tbl_addr[k] | ((i == 1) ? 16'hA000 : 16'h0000);
                send(i, 1'b1, a, {a, ~a}, k % 2, lat, rd, er);
                send(i, 1'b0, a, 32'h0, k, lat, rd, er);
                chk32("tbl_rdata", i, rd, {a, ~a});
            end
        end

        // reset during WAIT drops the store
        send(0, 1'b1, 16'h0020, 32'h22222222, 0, lat, rd, er);
        store_then_reset(0, 16'h0020, 32'h11111111, 0);
        send(0, 1'b0, 16'h0020, 32'h0, 0, lat, rd, er);
        chk32("rst_wait_rdata", 0, rd, 32'h22222222);

        // reset on the ACCESS edge drops the store; reset in RESP keeps it
        send(1, 1'b1, 16'h0030, 32'h33333333, 0, lat, rd, er);
        store_then_reset(1, 16'h0030, 32'h44444444, 0);
        send(1, 1'b0, 16'h0030, 32'h0, 0, lat, rd, er);
        chk32("rst_access_rdata", 1, rd, 32'h33333333);
        store_then_reset(1, 16'h0030, 32'h55555555, 1);
        send(1, 1'b0, 16'h0030, 32'h0, 0, lat, rd, er);
        chk32("rst_resp_rdata", 1, rd, 32'h55555555);

`ifdef DMEM_ACCESS_CNT_EN
        pulse_reset();
        send(0, 1'b1, 16'h0010, 32'h00000001, 0, lat, rd, er);
        send(0, 1'b1, 16'h0011, 32'h00000002, 0, lat, rd, er);
        send(0, 1'b0, 16'h0010, 32'h0, 0, lat, rd, er);
        send(0, 1'b0, 16'h0011, 32'h0, 0, lat, rd, er);
        send(0, 1'b0, 16'h0010, 32'h0, 0, lat, rd, er);
        send(0, 1'b1, 16'h0400, 32'h00000003, 0, lat, rd, er);
        @(negedge clk);
        chk32("cnt_ld", 0, ld_count[0], 32'd3);
        chk32("cnt_st", 0, st_count[0], 32'd2);
        chk32("cnt_err", 0, {16'd0, err_count[0]}, 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk32("cnt_ld_rst", 0, ld_count[0], 32'd0);
        chk32("cnt_st_rst", 0, st_count[0], 32'd0);
        chk32("cnt_err_rst", 0, {16'd0, err_count[0]}, 32'd0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
